uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//   UART receiver front end: samples the asynchronous serial line rxd and recovers 8N1 bytes
//   (8E1/8O1 with parity option), LSB first, using 16x oversampling with 3-sample majority vote.
//   Each good byte is presented on data_byte with a 1-cycle rxd_finish_pos strobe.
//   It directly feeds the downstream FF-AB-header frame parser, which consumes data_byte/rxd_finish_pos.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD        115200      line rate, bit/s; DIV = CLK_FREQ/(BAUD*16), integer-truncated, must be >= 2
//   PARITY_ODD  0           with UART_PARITY_EN: 0 = even parity, 1 = odd parity; ignored otherwise
// PORTS
//   clk             in   1  system clock, all logic on rising edge
//   reset_n         in   1  asynchronous active-low reset
//   rxd             in   1  serial line, asynchronous, idle high
//   data_byte       out  8  last good byte; holds until the next good byte
//   rxd_finish_pos  out  1  1-cycle pulse: data_byte valid, updated in the same cycle
//   frame_err       out  1  1-cycle pulse: stop bit sampled 0; byte discarded
//   parity_err      out  1  1-cycle pulse: parity mismatch, byte discarded (tied 0 without macro)
//   busy            out  1  high in any state except IDLE
// BEHAVIOUR
//   Reset: data_byte=8'h00, rxd_finish_pos=0, frame_err=0, parity_err=0, busy=0; sync FFs=1; state=IDLE.
//   Input: 2-FF synchroniser on rxd, plus a 3rd registered copy for edge detection.
//   Tick: counter 0..DIV-1; tick pulses when counter==DIV-1; cleared on start detect (phase align).
//   Sample counter s=0..15 advances per tick; bit value = majority of samples at s=7,8,9.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: falling edge on synchronised rxd (prev 1, now 0) -> START, s=0, tick counter cleared.
//     A line held low (break) never retriggers; it needs a return high and a new falling edge.
//   START: at s=9, majority=1 -> false start, back to IDLE with no pulse; else continue.
//     At s=15 + tick -> DATA with bit index 0.
//   DATA: shift the voted bit into bit[idx] (LSB first). At s=15 of bit 7 -> PARITY or STOP.
//   PARITY: the voted bit is checked against the XOR of the 8 data bits (inverted if PARITY_ODD).
//   STOP: decision at s=9, then immediate return to IDLE (half bit early, for resync).
//     Stop=1 and parity ok: data_byte loaded, rxd_finish_pos=1 for exactly one cycle.
//     Stop=0: frame_err pulse only. Parity bad (stop=1): parity_err pulse only.
//     Both bad: frame_err and parity_err together. data_byte is unchanged on any error.
//   Latency: strobe 1 clk after the stop-bit s=9 tick; ~2 extra clks of synchroniser delay.
//   Back-to-back frames with no idle gap are accepted, because STOP exits at mid-bit.
//   Tolerance: at least +-3% total baud mismatch for 8N1.
//   Reset mid-frame: the frame is abandoned and no pulse is emitted.
//   After reset, the next falling edge starts a fresh frame.
// CONFIGURATION
//   UART_PARITY_EN defined: PARITY state present, 11-bit frame, parity_err driven as above.
//   UART_PARITY_EN undefined: no PARITY state, 10-bit frame 8N1, parity_err tied 1'b0.
//     A 9th bit is then treated as the stop bit.
// STRUCTURE
//   Package uart_pkg: state encoding localparams (one-hot IDLE/START/DATA/PARITY/STOP),
//     OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, DATA_BITS=8.
//   Sub-module uart_baud_tick (params CLK_FREQ, BAUD; ports clk, reset_n, clear, tick).
//     It generates the 16x oversample tick and is reusable by the TX side.
//   Top level holds the synchroniser, majority voter, shift register and FSM.
// TESTING  (CLK_FREQ=50e6, BAUD=115200 -> DIV=27, 1 bit = 432 clk)
//   1) Send 0x55, 0xFF, 0xAB, 0x12, 0x34, 0x56 back-to-back -> six rxd_finish_pos pulses.
//      data_byte must match each byte; frame_err=0 throughout.
//   2) A 40-clk low glitch on an idle line -> no pulse on any output; busy back to 0 within 1 bit time.
//   3) Send 0xA5 with stop bit forced 0 -> frame_err 1-cycle pulse, no rxd_finish_pos.
//      data_byte keeps its prior value; the following good byte 0x3C is received.
//   4) Assert reset_n low at bit 4 of 0x81 -> all outputs reset.
//      The next frame 0x7E is received correctly.
//   5) Send 0xC3 at BAUD+3% and at BAUD-3% -> received correctly in both cases.
//   6) With UART_PARITY_EN and PARITY_ODD=0: 0x07 with parity 1 -> strobe;
//      0x07 with parity 0 -> parity_err only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and bit helpers for the UART receive path.
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam int         DATA_BITS  = 8;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] SAMPLE_END = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; clear re-phases the divider to the start edge.
module uart_baud_tick #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            DIV    = CLK_FREQ / (BAUD * 16);
  localparam int            CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wraps at DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == DIV_M1) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == DIV_M1) && !clear;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 16x oversampling with 3-sample majority vote, LSB first.
// Define UART_PARITY_EN for 8E1/8O1 framing (PARITY_ODD selects odd); default is 8N1.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data_byte,
  output logic       rxd_finish_pos,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

`ifdef UART_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  rx_state_e  state_r, state_n;
  logic       rxd_meta_r, rxd_sync_r, rxd_prev_r;
  logic [3:0] s_r, s_n;
  logic [2:0] idx_r, idx_n;
  logic [7:0] shift_r, shift_n;
  logic       v_lo_r, v_lo_n, v_mid_r, v_mid_n;
  logic [7:0] data_byte_r, data_n;
  logic       finish_r, finish_n, ferr_r, ferr_n, busy_r;
  logic       fall_s, vote_s, tick_s, clear_s;

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear_s),
    .tick   (tick_s)
  );

  assign fall_s = rxd_prev_r & ~rxd_sync_r;
  assign vote_s = majority3(v_lo_r, v_mid_r, rxd_sync_r);

`ifdef UART_PARITY_EN
  logic par_bit_r, par_bit_n, perr_r, perr_n, par_ok_s;
  assign par_ok_s   = (par_bit_r == (parity8(shift_r) ^ PARITY_ODD));
  assign parity_err = perr_r;

  // Parity bit capture and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit_r <= 1'b0;
      perr_r    <= 1'b0;
    end else begin
      par_bit_r <= par_bit_n;
      perr_r    <= perr_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Synchroniser, datapath and FSM state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_r  <= 1'b1;
      rxd_sync_r  <= 1'b1;
      rxd_prev_r  <= 1'b1;
      state_r     <= ST_IDLE;
      s_r         <= 4'd0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      v_lo_r      <= 1'b1;
      v_mid_r     <= 1'b1;
      data_byte_r <= 8'h00;
      finish_r    <= 1'b0;
      ferr_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rxd_meta_r  <= rxd;
      rxd_sync_r  <= rxd_meta_r;
      rxd_prev_r  <= rxd_sync_r;
      state_r     <= state_n;
      s_r         <= s_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      v_lo_r      <= v_lo_n;
      v_mid_r     <= v_mid_n;
      data_byte_r <= data_n;
      finish_r    <= finish_n;
      ferr_r      <= ferr_n;
      busy_r      <= (state_n != ST_IDLE);
    end
  end

  // Next-state and output decode; all bit decisions happen on the s=9 tick
  always_comb begin
    state_n  = state_r;
    s_n      = s_r;
    idx_n    = idx_r;
    shift_n  = shift_r;
    v_lo_n   = v_lo_r;
    v_mid_n  = v_mid_r;
    data_n   = data_byte_r;
    finish_n = 1'b0;
    ferr_n   = 1'b0;
    clear_s  = 1'b0;
`ifdef UART_PARITY_EN
    par_bit_n = par_bit_r;
    perr_n    = 1'b0;
`endif
    if (state_r == ST_IDLE) begin
      if (fall_s) begin
        state_n = ST_START;
        s_n     = 4'd0;
        clear_s = 1'b1;
      end else begin
        state_n = ST_IDLE;
      end
    end else if (tick_s) begin
      s_n = s_r + 4'd1;
      if (s_r == SAMPLE_LO) begin
        v_lo_n = rxd_sync_r;
      end else if (s_r == SAMPLE_MID) begin
        v_mid_n = rxd_sync_r;
      end else begin
        v_lo_n = v_lo_r;
      end
      case (state_r)
        ST_START: begin
          if (s_r == SAMPLE_HI && vote_s) begin
            state_n = ST_IDLE;
          end else if (s_r == SAMPLE_END) begin
            state_n = ST_DATA;
            idx_n   = 3'd0;
          end else begin
            state_n = ST_START;
          end
        end
        ST_DATA: begin
          if (s_r == SAMPLE_HI) begin
            shift_n[idx_r] = vote_s;
          end else if (s_r == SAMPLE_END) begin
            if (idx_r == LAST_BIT) begin
              state_n = AFTER_DATA;
            end else begin
              idx_n = idx_r + 3'd1;
            end
          end else begin
            state_n = ST_DATA;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (s_r == SAMPLE_HI) begin
            par_bit_n = vote_s;
          end else if (s_r == SAMPLE_END) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_PARITY;
          end
        end
`endif
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (s_r == SAMPLE_HI) begin
            state_n = ST_IDLE;
`ifdef UART_PARITY_EN
            if (vote_s && par_ok_s) begin
              data_n   = shift_r;
              finish_n = 1'b1;
            end else begin
              ferr_n = ~vote_s;
              perr_n = ~par_ok_s;
            end
`else
            if (vote_s) begin
              data_n   = shift_r;
              finish_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
`endif
          end else begin
            state_n = ST_STOP;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  assign data_byte      = data_byte_r;
  assign rxd_finish_pos = finish_r;
  assign frame_err      = ferr_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frames plus randomized traffic vs a frame-level model.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 390_625;
  localparam bit PAR_ODD  = 1'b0;
  localparam int BIT_CLKS = (CLK_FREQ / (BAUD * 16)) * 16;

  logic       clk, reset_n, rxd;
  logic [7:0] data_byte;
  logic       rxd_finish_pos, frame_err, parity_err, busy;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_ODD(PAR_ODD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rxd           (rxd),
    .data_byte     (data_byte),
    .rxd_finish_pos(rxd_finish_pos),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         got_fe = 0, got_pe = 0, exp_fe = 0, exp_pe = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rxd_finish_pos === 1'b1) rx_q.push_back(data_byte);
    if (frame_err === 1'b1) got_fe++;
    if (parity_err === 1'b1) got_pe++;
  end

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: a byte is delivered only with stop=1 and correct parity
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                            input int per, input int gap);
    logic pb;
    pb = (^b) ^ PAR_ODD ^ par_flip;
`ifdef UART_PARITY_EN
    if (stop_b && !par_flip) begin
      exp_q.push_back(b);
      last_good = b;
    end
    if (!stop_b) exp_fe++;
    if (par_flip) exp_pe++;
`else
    if (stop_b) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_fe++;
    end
`endif
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(b[i], per);
`ifdef UART_PARITY_EN
    drive(pb, per);
`endif
    drive(stop_b, per);
    if (gap > 0) drive(1'b1, gap);
  endtask

  task automatic check_rx(input string tag);
    drive(1'b1, 2 * BIT_CLKS);
    check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
    check_eq({tag, "_frame_err"}, got_fe, exp_fe);
    check_eq({tag, "_parity_err"}, got_pe, exp_pe);
    check_eq({tag, "_data_hold"}, data_byte, last_good);
    check_eq({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] t1_bytes[6];
    logic [7:0] rb;
    logic       rs, rp;
    t1_bytes = '{8'h55, 8'hFF, 8'hAB, 8'h12, 8'h34, 8'h56};
    rxd = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_data", data_byte, 8'h00);
    check_eq("rst_finish", rxd_finish_pos, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_perr", parity_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 20);

    // back-to-back bytes, no idle gap
    foreach (t1_bytes[i]) send_frame(t1_bytes[i], 1'b1, 1'b0, BIT_CLKS, 0);
    check_rx("b2b");

    // short low glitch is a false start
    drive(1'b0, BIT_CLKS / 10);
    rxd = 1'b1;
    check_eq("glitch_busy_hi", busy, 1'b1);
    drive(1'b1, BIT_CLKS);
    check_eq("glitch_busy_lo", busy, 1'b0);
    check_rx("glitch");

    // stop bit forced low, then a good byte
    send_frame(8'hA5, 1'b0, 1'b0, BIT_CLKS, BIT_CLKS);
    check_eq("ferr_data_hold", data_byte, last_good);
    send_frame(8'h3C, 1'b1, 1'b0, BIT_CLKS, 0);
    check_rx("stop0");

    // reset in the middle of bit 4 of 0x81
    rb = 8'h81;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(rb[i], BIT_CLKS);
    drive(rb[4], BIT_CLKS / 2);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_data", data_byte, 8'h00);
    check_eq("midrst_finish", rxd_finish_pos, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    drive(1'b1, 10);
    reset_n = 1'b1;
    last_good = 8'h00;
    drive(1'b1, BIT_CLKS);
    send_frame(8'h7E, 1'b1, 1'b0, BIT_CLKS, 0);
    check_rx("midrst");

    // +-3% line rate mismatch
    send_frame(8'hC3, 1'b1, 1'b0, (BIT_CLKS * 97) / 100, BIT_CLKS);
    send_frame(8'hC3, 1'b1, 1'b0, (BIT_CLKS * 103) / 100, BIT_CLKS);
    check_rx("baud_tol");

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS, BIT_CLKS);
    send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS, BIT_CLKS);
    send_frame(8'h5A, 1'b0, 1'b1, BIT_CLKS, BIT_CLKS);
    check_rx("parity");
`endif

    // randomized traffic; a bad stop bit is followed by idle so the next start edge exists
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      rp = ($urandom_range(0, 5) == 0);
      if (!rs) send_frame(rb, rs, rp, BIT_CLKS, BIT_CLKS);
      else if ($urandom_range(0, 1) == 0) send_frame(rb, rs, rp, BIT_CLKS, 0);
      else send_frame(rb, rs, rp, BIT_CLKS, $urandom_range(1, 2 * BIT_CLKS));
    end
    check_rx("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
